ctrl_sequencer: RTL and testbench

- Multi-cycle sequencer that drives the instruction-control decoder and its datapath (PC, IR, register file, data memory port).
- Latches the decoder's control lines once per instruction, then steps FETCH/DECODE/EXEC/MEM/WB.
- Owns the memory request/acknowledge handshake, a memory timeout, halt/resume and the retired-instruction counter.

---
 rtl/ctrl_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
// Multi-cycle instruction sequencer. It steps FETCH -> DECODE -> EXEC ->
// (MEM) -> (WB) and captures the decoder's control lines once per
// instruction, in DECODE. It also owns the memory request/ack handshake, a
// memory wait timeout, halt/resume, and the retired-instruction counter.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   halt_i .. jump_i  decoder control lines, sampled only in DECODE
//   cond_true_i       branch condition, used only in EXEC
//   mem_ack           memory acknowledge
//   resume            leave HALTED
//   fetch_req, ir_we  instruction fetch request, IR load strobe
//   mem_req, mem_we   data memory request and write qualifier
//   pc_we, pc_sel_tgt PC update strobe, 1 = load target / 0 = PC+2
//   rf_we             register file write strobe
//   halted, err       HALTED indicator, sticky memory timeout flag
//   state             FSM state (debug): FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALTED=5
//   retired           retired-instruction count, wraps
//
// Handshake: a request (fetch_req in FETCH, mem_req in MEM) stays high until
// the first cycle where mem_ack is also high. That cycle completes the
// transfer. mem_ack has no effect while neither request is high.
module ctrl_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_i,
    input  logic             reg_write_i,
    input  logic             mem_write_i,
    input  logic             sel_wb_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic             cond_true_i,
    input  logic             mem_ack,
    input  logic             resume,
    output logic             fetch_req,
    output logic             ir_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             pc_we,
    output logic             pc_sel_tgt,
    output logic             rf_we,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    // A timeout fires in the waiting cycle that would bring the count to TIMEOUT.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             reg_write_l_q, reg_write_l_d;
    logic             mem_write_l_q, mem_write_l_d;
    logic             sel_wb_l_q, sel_wb_l_d;
    logic             branch_l_q, branch_l_d;
    logic             jump_l_q, jump_l_d;
    logic [7:0]       tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             retire;
    logic             waiting;

    always_comb begin
        state_d       = state_q;
        reg_write_l_d = reg_write_l_q;
        mem_write_l_d = mem_write_l_q;
        sel_wb_l_d    = sel_wb_l_q;
        branch_l_d    = branch_l_q;
        jump_l_d      = jump_l_q;
        err_d         = err_q;
        retire        = 1'b0;
        waiting       = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (mem_ack) begin
                    state_d = ST_DECODE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_HALTED;
                    err_d   = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_DECODE: begin
                reg_write_l_d = reg_write_i;
                mem_write_l_d = mem_write_i;
                sel_wb_l_d    = sel_wb_i;
                branch_l_d    = branch_i;
                jump_l_d      = jump_i;
                // halt acts right here, so it never has to be held past DECODE.
                if (halt_i) begin
                    state_d = ST_HALTED;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (mem_write_l_q || sel_wb_l_q) begin
                    state_d = ST_MEM;
                end else if (reg_write_l_q) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (sel_wb_l_q && reg_write_l_q) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_HALTED;
                    err_d   = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // The count runs only while a request waits in the same state.
        // An ack, a timeout or any other state change clears it.
        tmo_cnt_d = waiting ? (tmo_cnt_q + 8'd1) : 8'd0;
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            reg_write_l_q <= 1'b0;
            mem_write_l_q <= 1'b0;
            sel_wb_l_q    <= 1'b0;
            branch_l_q    <= 1'b0;
            jump_l_q      <= 1'b0;
            tmo_cnt_q     <= 8'd0;
            err_q         <= 1'b0;
            retired_q     <= '0;
        end else begin
            state_q       <= state_d;
            reg_write_l_q <= reg_write_l_d;
            mem_write_l_q <= mem_write_l_d;
            sel_wb_l_q    <= sel_wb_l_d;
            branch_l_q    <= branch_l_d;
            jump_l_q      <= jump_l_d;
            tmo_cnt_q     <= tmo_cnt_d;
            err_q         <= err_d;
            retired_q     <= retired_d;
        end
    end

    // Outputs are decoded from registered state only. There are two
    // exceptions: ir_we follows mem_ack within the fetch cycle, and
    // pc_sel_tgt uses the EXEC-time condition. rst forces every output low,
    // so nothing strobes on a reset edge.
    always_comb begin
        fetch_req  = !rst && (state_q == ST_FETCH);
        ir_we      = fetch_req && mem_ack;
        mem_req    = !rst && (state_q == ST_MEM);
        mem_we     = mem_req && mem_write_l_q;
        pc_we      = !rst && (state_q == ST_EXEC);
        pc_sel_tgt = pc_we && (jump_l_q || (branch_l_q && cond_true_i));
        rf_we      = !rst && (state_q == ST_WB);
        halted     = !rst && (state_q == ST_HALTED);
        err        = !rst && err_q;
        state      = rst ? 3'd0 : state_q;
        retired    = rst ? '0 : retired_q;
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer. Instance a uses the default parameters.
// Instance b uses CNT_W=4 and TIMEOUT=3, for the timeout, reset and wrap
// cases. Both instances share the decoder and memory inputs, and each has
// its own reset. The observed outputs of the selected instance are packed as
//   {4'b0, fetch_req, ir_we, mem_req, mem_we, pc_we, pc_sel_tgt, rf_we,
//    halted, err, state[2:0]}
module tb_ctrl_sequencer;

    localparam logic [15:0] B_FREQ  = 16'h0800;
    localparam logic [15:0] B_IRWE  = 16'h0400;
    localparam logic [15:0] B_MREQ  = 16'h0200;
    localparam logic [15:0] B_MWE   = 16'h0100;
    localparam logic [15:0] B_PCWE  = 16'h0080;
    localparam logic [15:0] B_PCSEL = 16'h0040;
    localparam logic [15:0] B_RFWE  = 16'h0020;
    localparam logic [15:0] B_HALT  = 16'h0010;
    localparam logic [15:0] B_ERR   = 16'h0008;
    localparam logic [15:0] S_FETCH  = 16'd0;
    localparam logic [15:0] S_DECODE = 16'd1;
    localparam logic [15:0] S_EXEC   = 16'd2;
    localparam logic [15:0] S_MEM    = 16'd3;
    localparam logic [15:0] S_WB     = 16'd4;
    localparam logic [15:0] S_HALTED = 16'd5;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_a, rst_b;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic halt_i, reg_write_i, mem_write_i, sel_wb_i, branch_i, jump_i;
    logic cond_true_i, mem_ack, resume;
    logic use_b;

    wire [15:0] a_obs, b_obs;
    wire [15:0] a_ret;
    wire [3:0]  b_ret;
    logic [15:0] o_obs, o_ret;

    assign a_obs[15:12] = 4'd0;
    assign b_obs[15:12] = 4'd0;
    assign o_obs = use_b ? b_obs : a_obs;
    assign o_ret = use_b ? {12'd0, b_ret} : a_ret;

    ctrl_sequencer #(.CNT_W(16), .TIMEOUT(15)) dut_a (
        .clk(clk), .rst(rst_a),
        .halt_i(halt_i), .reg_write_i(reg_write_i), .mem_write_i(mem_write_i),
        .sel_wb_i(sel_wb_i), .branch_i(branch_i), .jump_i(jump_i),
        .cond_true_i(cond_true_i), .mem_ack(mem_ack), .resume(resume),
        .fetch_req(a_obs[11]), .ir_we(a_obs[10]), .mem_req(a_obs[9]),
        .mem_we(a_obs[8]), .pc_we(a_obs[7]), .pc_sel_tgt(a_obs[6]),
        .rf_we(a_obs[5]), .halted(a_obs[4]), .err(a_obs[3]),
        .state(a_obs[2:0]), .retired(a_ret)
    );

    ctrl_sequencer #(.CNT_W(4), .TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst_b),
        .halt_i(halt_i), .reg_write_i(reg_write_i), .mem_write_i(mem_write_i),
        .sel_wb_i(sel_wb_i), .branch_i(branch_i), .jump_i(jump_i),
        .cond_true_i(cond_true_i), .mem_ack(mem_ack), .resume(resume),
        .fetch_req(b_obs[11]), .ir_we(b_obs[10]), .mem_req(b_obs[9]),
        .mem_we(b_obs[8]), .pc_we(b_obs[7]), .pc_sel_tgt(b_obs[6]),
        .rf_we(b_obs[5]), .halted(b_obs[4]), .err(b_obs[3]),
        .state(b_obs[2:0]), .retired(b_ret)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int exp_ret = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%04h expected=%04h", tag, got, exp);
        end
    endtask

    task automatic note_retire();
        exp_ret = use_b ? ((exp_ret + 1) % 16) : ((exp_ret + 1) % 65536);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic check_ret(input string tag);
        look();
        chk(tag, o_ret, 16'(exp_ret));
    endtask

    task automatic do_fetch(input int waits);
        for (int i = 0; i < waits; i++) begin
            look();
            chk("fetch_wait", o_obs, B_FREQ | S_FETCH);
            tick();
        end
        mem_ack = 1'b1;
        look();
        chk("fetch_ack", o_obs, B_FREQ | B_IRWE | S_FETCH);
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic do_decode(input logic h, input logic rw, input logic mw,
                             input logic swb, input logic br, input logic jp);
        halt_i = h; reg_write_i = rw; mem_write_i = mw;
        sel_wb_i = swb; branch_i = br; jump_i = jp;
        look();
        chk("decode", o_obs, S_DECODE);
        tick();
        // Clear the decoder lines so later states must use the latched copies.
        halt_i = 0; reg_write_i = 0; mem_write_i = 0;
        sel_wb_i = 0; branch_i = 0; jump_i = 0;
    endtask

    task automatic do_exec(input logic cond, input logic tgt);
        cond_true_i = cond;
        look();
        chk("exec", o_obs, B_PCWE | (tgt ? B_PCSEL : 16'd0) | S_EXEC);
        tick();
        cond_true_i = 1'b0;
    endtask

    task automatic do_mem(input int waits, input logic we);
        logic [15:0] m;
        m = B_MREQ | (we ? B_MWE : 16'd0) | S_MEM;
        for (int i = 0; i < waits; i++) begin
            look();
            chk("mem_wait", o_obs, m);
            tick();
        end
        mem_ack = 1'b1;
        look();
        chk("mem_ack", o_obs, m);
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic do_wb();
        look();
        chk("wb", o_obs, B_RFWE | S_WB);
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach the end");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_a = 1; rst_b = 1; use_b = 0;
        halt_i = 0; reg_write_i = 0; mem_write_i = 0; sel_wb_i = 0;
        branch_i = 0; jump_i = 0; cond_true_i = 0; mem_ack = 0; resume = 0;
        tick(); tick();
        look();
        chk("rst_a_outputs", o_obs, 16'd0);
        chk("rst_a_retired", o_ret, 16'd0);
        rst_a = 0;
        look();
        chk("reset_state", o_obs, B_FREQ | S_FETCH);

        // ALU op: 4 cycles, WB strobe, one retire
        do_fetch(0);
        do_decode(0, 1, 0, 0, 0, 0);
        do_exec(0, 0);
        check_ret("alu_ret_in_wb");
        do_wb();
        note_retire();
        check_ret("alu_ret");

        // Load with a 3-cycle memory wait
        do_fetch(0);
        do_decode(0, 1, 0, 1, 0, 0);
        do_exec(0, 0);
        do_mem(3, 0);
        do_wb();
        note_retire();
        check_ret("load_ret");

        // Store: no WB
        do_fetch(0);
        do_decode(0, 0, 1, 0, 0, 0);
        do_exec(0, 0);
        do_mem(1, 1);
        note_retire();
        check_ret("store_ret");

        // Branch taken, branch not taken, jump
        do_fetch(0);
        do_decode(0, 0, 0, 0, 1, 0);
        do_exec(1, 1);
        note_retire();
        do_fetch(0);
        do_decode(0, 0, 0, 0, 1, 0);
        do_exec(0, 0);
        note_retire();
        do_fetch(0);
        do_decode(0, 0, 0, 0, 0, 1);
        do_exec(0, 1);
        note_retire();
        check_ret("branch_ret");

        // Halt and resume
        do_fetch(0);
        do_decode(1, 0, 0, 0, 0, 0);
        note_retire();
        look();
        chk("halted", o_obs, B_HALT | S_HALTED);
        check_ret("halt_ret");
        mem_ack = 1;
        tick();
        look();
        chk("halt_ignores_ack", o_obs, B_HALT | S_HALTED);
        mem_ack = 0;
        resume = 1;
        tick();
        resume = 0;
        look();
        chk("resume", o_obs, B_FREQ | S_FETCH);

        // Switch to instance b (TIMEOUT=3, CNT_W=4)
        rst_a = 1;
        use_b = 1;
        exp_ret = 0;
        look();
        chk("rst_b_outputs", o_obs, 16'd0);
        rst_b = 0;
        look();
        chk("b_reset_state", o_obs, B_FREQ | S_FETCH);

        // Fetch timeout: three waiting cycles, then HALTED with err
        for (int i = 0; i < 3; i++) begin
            look();
            chk("tmo_wait", o_obs, B_FREQ | S_FETCH);
            tick();
        end
        look();
        chk("tmo_halt", o_obs, B_HALT | B_ERR | S_HALTED);
        check_ret("tmo_no_retire");
        resume = 1;
        tick();
        resume = 0;
        look();
        chk("err_sticky", o_obs, B_FREQ | B_ERR | S_FETCH);
        rst_b = 1;
        tick();
        rst_b = 0;
        look();
        chk("err_cleared", o_obs, B_FREQ | S_FETCH);

        // An ack in the cycle the count would reach TIMEOUT wins, in FETCH and MEM
        do_fetch(2);
        do_decode(0, 0, 1, 0, 0, 0);
        do_exec(0, 0);
        do_mem(2, 1);
        note_retire();
        check_ret("ack_wins_ret");
        look();
        chk("ack_wins_no_err", o_obs, B_FREQ | S_FETCH);

        // Memory timeout in MEM
        do_fetch(0);
        do_decode(0, 0, 1, 0, 0, 0);
        do_exec(0, 0);
        for (int i = 0; i < 3; i++) begin
            look();
            chk("mem_tmo_wait", o_obs, B_MREQ | B_MWE | S_MEM);
            tick();
        end
        look();
        chk("mem_tmo_halt", o_obs, B_HALT | B_ERR | S_HALTED);
        check_ret("mem_tmo_no_retire");

        // Reset in the middle of a load in MEM
        rst_b = 1;
        tick();
        rst_b = 0;
        exp_ret = 0;
        do_fetch(0);
        do_decode(0, 0, 0, 0, 0, 0);
        do_exec(0, 0);
        note_retire();
        check_ret("pre_rst_ret");
        do_fetch(0);
        do_decode(0, 1, 0, 1, 0, 0);
        do_exec(0, 0);
        look();
        chk("mem_before_rst", o_obs, B_MREQ | S_MEM);
        rst_b = 1;
        look();
        chk("rst_forces_zero", o_obs, 16'd0);
        chk("rst_forces_ret", o_ret, 16'd0);
        tick();
        look();
        chk("rst_hold", o_obs, 16'd0);
        rst_b = 0;
        exp_ret = 0;
        look();
        chk("after_rst", o_obs, B_FREQ | S_FETCH);
        check_ret("after_rst_ret");

        // Retired counter wrap at CNT_W=4
        for (int i = 0; i < 15; i++) begin
            do_fetch(0);
            do_decode(0, 0, 0, 0, 0, 0);
            do_exec(0, 0);
            note_retire();
        end
        check_ret("ret_15");
        do_fetch(0);
        do_decode(0, 0, 0, 0, 0, 0);
        do_exec(0, 0);
        note_retire();
        check_ret("ret_wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
